// File: rtl/mlp_in_packer.sv
// mlp_in_packer: quantizes a stream of signed samples into magnitude/polarity
// elements, buffers one frame of N1/2 elements, appends the bias element and
// streams the frame to the serial MLP core as N_BEATS back-to-back P-lane
// beats. The next frame is accepted only after the core reports completion.
// Optional feature macro: MLP_IN_PACKER_ROUND_EN (round-half-up before shift).
module mlp_in_packer #(
  parameter int N1    = 98,
  parameter int P     = 2,
  parameter int W_X   = 4,
  parameter int W_S   = 8,
  parameter int SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [W_S-1:0] s_data,
  input  logic                  s_vld,
  output logic                  s_rdy,
  output logic [P*W_X-1:0]      in_mag,
  output logic [P*2-1:0]        in_pol,
  output logic                  in_vld,
  input  logic                  mlp_done,
  output logic                  busy
);

  localparam int N_HALF  = N1 / 2;
  localparam int N_ELEM  = N_HALF + 1;
  localparam int N_BEATS = (N_ELEM + P - 1) / P;
  localparam int CW      = $clog2(N_HALF + 1);
  localparam int BW      = $clog2(N_BEATS + 1);

  localparam logic [W_X-1:0]   MAG_SAT  = '1;
  localparam logic [W_S+1:0]   MAG_LIM  = (W_S+2)'((1 << W_X) - 1);
  localparam logic [W_S+1:0]   RND_HALF = (SHIFT > 0) ?
                                          ((W_S+2)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) :
                                          (W_S+2)'(0);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [BW-1:0]    r_idx;
  logic [BW-1:0]    w_idx_nxt;
  logic [BW-1:0]    w_sel;
  logic             w_vld_nxt;
  logic             w_xfer;
  logic [P*W_X-1:0] w_mag_nxt;
  logic [P*2-1:0]   w_pol_nxt;
  logic             r_s_rdy;
  logic             r_busy;
  logic             r_in_vld;
  logic [P*W_X-1:0] r_in_mag;
  logic [P*2-1:0]   r_in_pol;
  logic [W_X-1:0]   r_mag_buf [N_HALF];
  logic [1:0]       r_pol_buf [N_HALF];

  // |s| is formed one bit wider so the most negative sample is exact.
  function automatic logic [W_X-1:0] quant_mag(input logic signed [W_S-1:0] s);
    logic signed [W_S:0] sx;
    logic [W_S+1:0]      a;
    logic [W_S+1:0]      sh;
    sx = {s[W_S-1], s};
    if (sx[W_S]) begin
      a = {1'b0, unsigned'(-sx)};
    end else begin
      a = {1'b0, unsigned'(sx)};
    end
`ifdef MLP_IN_PACKER_ROUND_EN
    a = a + RND_HALF;
`else
    a = a + (RND_HALF & (W_S+2)'(0));
`endif
    sh = a >> SHIFT;
    if (sh > MAG_LIM) begin
      return MAG_SAT;
    end else begin
      return sh[W_X-1:0];
    end
  endfunction

  // Polarity code: +1 -> 01, -1 -> 11, zero -> 00.
  function automatic logic [1:0] quant_pol(input logic signed [W_S-1:0] s);
    if (s == W_S'(0)) begin
      return 2'b00;
    end else if (s[W_S-1]) begin
      return 2'b11;
    end else begin
      return 2'b01;
    end
  endfunction

  assign w_xfer = s_vld && r_s_rdy && (r_state == ST_FILL);
  assign w_sel  = r_idx - BW'(1);

  // Element buffer: quantize and store each accepted sample at its index.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_mag_buf[r_cnt] <= quant_mag(s_data);
      r_pol_buf[r_cnt] <= quant_pol(s_data);
    end
  end

  // Beat assembly: map element k = beat*P + lane to samples, bias or padding.
  always_comb begin
    int            k;
    logic [CW-1:0] ki;
    w_mag_nxt = '0;
    w_pol_nxt = '0;
    k         = 0;
    ki        = '0;
    for (int l = 0; l < P; l++) begin
      k  = int'(w_sel) * P + l;
      ki = k[CW-1:0];
      if (k < N_HALF) begin
        w_mag_nxt[l*W_X +: W_X] = r_mag_buf[ki];
        w_pol_nxt[l*2 +: 2]     = r_pol_buf[ki];
      end else if (k == N_HALF) begin
        w_mag_nxt[l*W_X +: W_X] = W_X'(1);
        w_pol_nxt[l*2 +: 2]     = 2'b00;
      end else begin
        w_mag_nxt[l*W_X +: W_X] = W_X'(0);
        w_pol_nxt[l*2 +: 2]     = 2'b00;
      end
    end
  end

  // Next-state logic: SEND spends one idle cycle, then N_BEATS valid beats.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_vld_nxt   = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_xfer) begin
          if (r_cnt == CW'(N_HALF - 1)) begin
            w_state_nxt = ST_SEND;
            w_cnt_nxt   = CW'(0);
            w_idx_nxt   = BW'(0);
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_SEND: begin
        w_idx_nxt = r_idx + BW'(1);
        if (r_idx != BW'(0)) begin
          w_vld_nxt = 1'b1;
        end else begin
          w_vld_nxt = 1'b0;
        end
        if (r_idx == BW'(N_BEATS)) begin
          w_state_nxt = ST_WAIT;
          w_idx_nxt   = BW'(0);
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (mlp_done) begin
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
        w_cnt_nxt   = CW'(0);
        w_idx_nxt   = BW'(0);
      end
    endcase
  end

  // State and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_FILL;
      r_cnt    <= CW'(0);
      r_idx    <= BW'(0);
      r_s_rdy  <= 1'b1;
      r_busy   <= 1'b0;
      r_in_vld <= 1'b0;
      r_in_mag <= '0;
      r_in_pol <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_s_rdy  <= (w_state_nxt == ST_FILL);
      r_busy   <= (w_state_nxt != ST_FILL);
      r_in_vld <= w_vld_nxt;
      r_in_mag <= w_vld_nxt ? w_mag_nxt : '0;
      r_in_pol <= w_vld_nxt ? w_pol_nxt : '0;
    end
  end

  assign s_rdy  = r_s_rdy;
  assign busy   = r_busy;
  assign in_vld = r_in_vld;
  assign in_mag = r_in_mag;
  assign in_pol = r_in_pol;

endmodule

// File: tb/tb_mlp_in_packer.sv
// Testbench for mlp_in_packer: two instances (SHIFT=3 and SHIFT=0) share the
// input stream; captured beats are compared with a frame model built from the
// sample array using plain arithmetic.
module tb_mlp_in_packer;

  localparam int NS = 49;
  localparam int NB = 25;
`ifdef MLP_IN_PACKER_ROUND_EN
  localparam int EXP12 = 2;
`else
  localparam int EXP12 = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_vld;
  logic       mlp_done;
  logic       s_rdy, in_vld, busy;
  logic [7:0] in_mag;
  logic [3:0] in_pol;
  logic       s_rdy0, in_vld0, busy0;
  logic [7:0] in_mag0;
  logic [3:0] in_pol0;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int e0     = 0;
  int rise_cyc = 0;
  int run    = 0;
  bit prev_vld = 1'b0;
  bit mon_en = 1'b0;
  int smp [NS];
  logic [7:0] q_mag [$];
  logic [3:0] q_pol [$];
  logic [7:0] q0_mag [$];
  logic [3:0] q0_pol [$];
  logic [7:0] sv_mag [$];
  logic [3:0] sv_pol [$];
  int runs [$];

  mlp_in_packer u_dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .in_mag(in_mag), .in_pol(in_pol), .in_vld(in_vld), .mlp_done(mlp_done), .busy(busy)
  );

  mlp_in_packer #(.SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy0),
    .in_mag(in_mag0), .in_pol(in_pol0), .in_vld(in_vld0), .mlp_done(mlp_done), .busy(busy0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: quantize one sample with the given shift.
  function automatic int qm(input int s, input int sh);
    int a;
    a = (s < 0) ? -s : s;
`ifdef MLP_IN_PACKER_ROUND_EN
    if (sh > 0) a = a + (1 << (sh - 1));
`endif
    a = a >> sh;
    return (a > 15) ? 15 : a;
  endfunction

  function automatic int qp(input int s);
    return (s > 0) ? 1 : ((s < 0) ? 3 : 0);
  endfunction

  function automatic int el_mag(input int k, input int sh);
    if (k < NS) return qm(smp[k], sh);
    else if (k == NS) return 1;
    else return 0;
  endfunction

  function automatic int el_pol(input int k);
    if (k < NS) return qp(smp[k]);
    else return 0;
  endfunction

  function automatic int beat_mag(input int b, input int sh);
    return el_mag(2*b, sh) | (el_mag(2*b+1, sh) << 4);
  endfunction

  function automatic int beat_pol(input int b);
    return el_pol(2*b) | (el_pol(2*b+1) << 2);
  endfunction

  // Beat capture and idle-output check, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_vld) begin
        q_mag.push_back(in_mag);
        q_pol.push_back(in_pol);
        if (!prev_vld) rise_cyc = cyc;
        run++;
      end else begin
        if (prev_vld) runs.push_back(run);
        run = 0;
        chk("idle_zero", {in_mag, in_pol}, 32'd0);
      end
      if (in_vld0) begin
        q0_mag.push_back(in_mag0);
        q0_pol.push_back(in_pol0);
      end
      prev_vld = in_vld;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_mag.delete(); q_pol.delete(); q0_mag.delete(); q0_pol.delete(); runs.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < NS; i++) smp[i] = int'($urandom_range(255, 0)) - 128;
  endtask

  task automatic send_frame(input bit gaps, input bit hold);
    int g;
    for (int i = 0; i < NS; i++) begin
      g = 0;
      while (gaps && g < 8 && $urandom_range(1, 0) == 1) begin
        s_vld = 1'b0;
        tick();
        g++;
      end
      s_data = smp[i][7:0];
      s_vld  = 1'b1;
      if (!s_rdy) chk("rdy_in_fill", {31'd0, s_rdy}, 32'd1);
      tick();
    end
    e0 = cyc;
    chk("rdy_fall", {31'd0, s_rdy}, 32'd0);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    if (hold) s_data = 8'($urandom_range(255, 0));
    else s_vld = 1'b0;
  endtask

  task automatic wait_frame();
    int t;
    t = 0;
    while (runs.size() == 0 && t < 100) begin
      tick();
      t++;
    end
    chk("frame_end", runs.size(), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_nbeats"}, q_mag.size(), NB);
    chk({tag, "_nbeats0"}, q0_mag.size(), NB);
    chk({tag, "_runs"}, runs.size(), 32'd1);
    if (runs.size() > 0) chk({tag, "_runlen"}, runs[0], NB);
    chk({tag, "_latency"}, rise_cyc, e0 + 2);
    for (int b = 0; b < NB && b < q_mag.size(); b++) begin
      chk({tag, "_mag"}, q_mag[b], beat_mag(b, 3));
      chk({tag, "_pol"}, q_pol[b], beat_pol(b));
    end
    for (int b = 0; b < NB && b < q0_mag.size(); b++) begin
      chk({tag, "_mag0"}, q0_mag[b], beat_mag(b, 0));
      chk({tag, "_pol0"}, q0_pol[b], beat_pol(b));
    end
  endtask

  task automatic do_frame(input bit gaps, input bit hold, input bit done_in_send, input string tag);
    clear_q();
    send_frame(gaps, hold);
    if (done_in_send) begin
      repeat (5) tick();
      mlp_done = 1'b1;
      tick();
      mlp_done = 1'b0;
    end
    wait_frame();
    repeat (29) tick();
    chk({tag, "_rdy_wait"}, {31'd0, s_rdy}, 32'd0);
    chk({tag, "_busy_wait"}, {31'd0, busy}, 32'd1);
    mlp_done = 1'b1;
    tick();
    mlp_done = 1'b0;
    s_vld    = 1'b0;
    chk({tag, "_rdy_done"}, {31'd0, s_rdy}, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check_frame(tag);
  endtask

  initial begin
    int t;
    rst = 1'b0; s_vld = 1'b0; s_data = 8'd0; mlp_done = 1'b0;
    repeat (3) tick();
    chk("rst_rdy", {31'd0, s_rdy}, 32'd1);
    chk("rst_vld", {31'd0, in_vld}, 32'd0);
    chk("rst_mag", in_mag, 32'd0);
    chk("rst_pol", in_pol, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    tick();
    mon_en = 1'b1;

    // Ramp 0..48, gapless, s_vld held through SEND/WAIT, stray done in SEND.
    for (int i = 0; i < NS; i++) smp[i] = i;
    do_frame(1'b0, 1'b1, 1'b1, "ramp");
    if (q_mag.size() > 24) begin
      chk("ramp_b0_mag", q_mag[0], 32'h00);
      chk("ramp_b0_pol", q_pol[0], 32'h4);
      chk("ramp_b4_mag", q_mag[4], 32'h11);
      chk("ramp_b4_pol", q_pol[4], 32'h5);
      chk("ramp_b24_mag", q_mag[24], 32'h16);
      chk("ramp_b24_pol", q_pol[24], 32'h1);
    end
    sv_mag = q_mag;
    sv_pol = q_pol;

    // Extremes.
    fill_random();
    smp[0] = -128; smp[1] = 127; smp[2] = -9; smp[3] = 0; smp[4] = 100;
    do_frame(1'b0, 1'b0, 1'b0, "ext");
    if (q_mag.size() > 2 && q0_mag.size() > 2) begin
      chk("ext_b0_mag", q_mag[0], 32'hFF);
      chk("ext_b0_pol", q_pol[0], 32'h7);
      chk("ext_b1_mag", q_mag[1], 32'h01);
      chk("ext_b1_pol", q_pol[1], 32'h3);
      chk("ext_sh0_100", {28'd0, q0_mag[2][3:0]}, 32'd15);
    end

    // Same ramp with random s_vld gaps must give identical beats.
    for (int i = 0; i < NS; i++) smp[i] = i;
    do_frame(1'b1, 1'b0, 1'b0, "gaps");
    for (int b = 0; b < NB && b < q_mag.size() && b < sv_mag.size(); b++) begin
      chk("gaps_same_mag", q_mag[b], sv_mag[b]);
      chk("gaps_same_pol", q_pol[b], sv_pol[b]);
    end

    // Reset after beat 10 of SEND, then a fresh frame.
    clear_q();
    fill_random();
    send_frame(1'b0, 1'b0);
    t = 0;
    while (q_mag.size() < 11 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("mid_send_beats", q_mag.size(), 32'd11);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("srst_vld", {31'd0, in_vld}, 32'd0);
    chk("srst_out", {in_mag, in_pol}, 32'd0);
    chk("srst_rdy", {31'd0, s_rdy}, 32'd1);
    chk("srst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #1;
    fill_random();
    do_frame(1'b0, 1'b0, 1'b0, "post_rst");

    // Rounding-sensitive values.
    fill_random();
    smp[0] = 12; smp[1] = -12;
    do_frame(1'b1, 1'b0, 1'b0, "rnd");
    if (q_mag.size() > 0) begin
      chk("rnd_b0_mag", q_mag[0], (EXP12 << 4) | EXP12);
      chk("rnd_b0_pol", q_pol[0], 32'hD);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mlp_in_packer.md
Name: mlp_in_packer

Overview:
- Upstream feeder for the serial MLP denoiser core.
- Accepts a stream of signed raw samples and quantizes each into the core's magnitude/polarity format.
- Buffers one frame of N1/2 samples, appends the bias element, and emits the frame as N_BEATS back-to-back P-lane beats on the core's in_vld/in_mag/in_pol inputs.
- Waits for the core's out_vld before accepting the next frame.

Parameters:
N1, 98, MLP first-layer width; frame holds N1/2 samples plus 1 bias element
P, 2, lanes per output beat
W_X, 4, output magnitude width
W_S, 8, signed input sample width
SHIFT, 3, right-shift applied to |sample| before saturation
(derived) N_ELEM = N1/2+1; N_BEATS = ceil(N_ELEM/P) = 25 at defaults

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
s_data  in  W_S  signed input sample
s_vld  in  1  s_data valid
s_rdy  out  1  packer can accept; transfer when s_vld && s_rdy at rising edge
in_mag  out  P*W_X  packed [P-1:0][W_X-1:0] lane magnitudes to core
in_pol  out  P*2  packed [P-1:0][1:0] lane polarity codes to core
in_vld  out  1  beat valid to core
mlp_done  in  1  core out_vld; one-cycle pulse ending the frame
busy  out  1  high in SEND or WAIT

Behaviour:
- Reset (rst==0 at edge): state FILL, counters 0, s_rdy=1, in_vld=0, in_mag=0, in_pol=0, busy=0. Any partial frame is discarded, including reset mid-FILL/SEND/WAIT.
- Quantization per accepted sample s:
  - a = |s|, computed W_S+1 wide so -2^(W_S-1) is exact.
  - mag = min(a >> SHIFT, 2^W_X-1).
  - pol = 2'b01 if s>0, 2'b11 (-1) if s<0, 2'b00 if s==0.
  - Results are stored in an element buffer at index cnt.
- Element order: element k goes to beat k/P, lane k%P.
  - Element N1/2 is the bias: mag=1, pol=2'b00.
  - Elements >= N_ELEM (padding) are mag=0, pol=0.
- FSM:
  - FILL: s_rdy=1; each transfer stores one element, cnt++. On the transfer with cnt==N1/2-1, go to SEND; s_rdy=0 from the next cycle.
  - SEND: all outputs registered. in_vld is high for exactly N_BEATS consecutive cycles, starting the 2nd rising edge after the last accepting edge, beat index 0..N_BEATS-1. No gaps; the core provides no backpressure. After the last beat go to WAIT.
  - WAIT: in_vld=0. On mlp_done==1 go to FILL; s_rdy=1 from the next cycle.
- mlp_done is ignored outside WAIT.
- When in_vld=0, in_mag and in_pol are driven to 0.
- s_vld while s_rdy=0 has no effect; the upstream must hold the sample.
- Gaps in s_vld during FILL are allowed; the output frame is identical to gapless input.

Optional Feature:
- Macro: MLP_IN_PACKER_ROUND_EN.
- Defined, and SHIFT>0: mag = min((a + 2^(SHIFT-1)) >> SHIFT, 2^W_X-1), i.e. round-half-up.
- Undefined, or SHIFT==0: truncating shift as above.
- Polarity and all timing are unaffected either way.

Test Plan:
1. Ramp s=0..48, gapless, defaults.
   - in_vld high exactly 25 consecutive cycles.
   - beat0 = {lane0: mag0 pol00, lane1: mag0 pol01}.
   - beat4 lane0 (s=8): mag1, pol01.
   - beat24 lane0 (s=48): mag6, pol01; beat24 lane1 (bias): mag1, pol00.
2. Extremes: s=-128 -> mag15 pol11; s=127 -> mag15 pol01; s=-9 -> mag1 pol11; s=0 -> mag0 pol00. SHIFT=0, s=100 -> mag15.
3. Handshake:
   - s_rdy falls after the 49th transfer.
   - s_vld held high through SEND/WAIT produces no transfers.
   - mlp_done pulsed 30 cycles after the last beat -> s_rdy=1 the following cycle.
   - A mlp_done pulse during SEND is ignored.
4. Random s_vld gaps (~50% duty), same 49 samples as scenario 1 -> beat-for-beat identical output.
5. rst=0 for one cycle after beat 10 of SEND.
   - Next cycle: in_vld=0, outputs 0, s_rdy=1, busy=0.
   - A fresh 49-sample frame is then emitted correctly.
6. SHIFT=3, s=12 and s=-12: mag1 without MLP_IN_PACKER_ROUND_EN; mag2 with it. pol 01 / 11 in both builds.
